// File: rtl/jt6295_pkg.sv
// Shared types and constants for the jt6295 ROM arbiter slice.
package jt6295_pkg;
  localparam int CH_N   = 4;
  localparam int ROM_AW = 18;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Requester ids 0-3 are the channels; the control path sits just above them.
  localparam logic [2:0] REQ_CTRL = 3'd4;
endpackage

// File: rtl/jt6295_rr4.sv
// Combinational 4-way round-robin picker: first requester at or above ptr, mod 4.
module jt6295_rr4
  import jt6295_pkg::*;
(
  input  logic [CH_N-1:0] req,
  input  logic [1:0]      ptr,
  output logic [1:0]      gnt,
  output logic            valid
);
  logic [1:0] idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    // Scan from the farthest slot down so the nearest requester is written last.
    for (int i = CH_N - 1; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) begin
        gnt   = idx;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/jt6295_rom_arb.sv
// Shares the ADPCM sample ROM port between the phrase-table reader and the four
// channel fetchers, with a settle window on rom_ok and an optional WAIT timeout.
module jt6295_rom_arb
  import jt6295_pkg::*;
#(
  parameter int SETTLE = 1,   // 1-3
  parameter int TOUT   = 255  // 0 disables, at most 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ctrl_req,
  input  logic [9:0]             ctrl_addr,
  output logic [7:0]             ctrl_data,
  output logic                   ctrl_ok,
  input  logic [CH_N-1:0]        ch_req,
  input  logic [CH_N*ROM_AW-1:0] ch_addr,
  output logic [7:0]             ch_data,
  output logic [CH_N-1:0]        ch_ok,
  output logic [ROM_AW-1:0]      rom_addr,
  output logic                   rom_cs,
  input  logic [7:0]             rom_data,
  input  logic                   rom_ok,
  output logic                   timeout
);
  state_t                      state, state_nx;
  logic [7:0]                  cnt, cnt_nx;
  logic [2:0]                  id, id_nx;
  logic [1:0]                  rr_ptr, rr_ptr_nx;
  logic                        last_ctrl, last_ctrl_nx;
  logic [ROM_AW-1:0]           rom_addr_nx;
  logic                        rom_cs_nx, timeout_nx;
  logic [7:0]                  ctrl_data_nx, ch_data_nx, cap;
  logic                        capture;
  logic [CH_N-1:0][ROM_AW-1:0] ch_addr_a;
  logic [1:0]                  rr_gnt;
  logic                        rr_valid;
  logic                        tout_hit;

  assign ch_addr_a = ch_addr;
  assign tout_hit  = (TOUT > 0) && (cnt == 8'(TOUT - 1));

  jt6295_rr4 u_rr (
    .req   (ch_req),
    .ptr   (rr_ptr),
    .gnt   (rr_gnt),
    .valid (rr_valid)
  );

  always_comb begin
    // NOTE: every next-value defaults to its register first, so no branch can infer a latch.
    state_nx     = state;
    cnt_nx       = cnt;
    id_nx        = id;
    rr_ptr_nx    = rr_ptr;
    last_ctrl_nx = last_ctrl;
    rom_addr_nx  = rom_addr;
    rom_cs_nx    = rom_cs;
    timeout_nx   = timeout;
    ctrl_data_nx = ctrl_data;
    ch_data_nx   = ch_data;
    cap          = 8'h00;
    capture      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // Ctrl may not win twice in a row while any channel is waiting.
        if (ctrl_req && (!last_ctrl || ch_req == '0)) begin
          id_nx        = REQ_CTRL;
          rom_addr_nx  = {8'd0, ctrl_addr};
          last_ctrl_nx = 1'b1;
          rom_cs_nx    = 1'b1;
          cnt_nx       = '0;
          state_nx     = ST_SETTLE;
        end else if (rr_valid) begin
          id_nx        = {1'b0, rr_gnt};
          rom_addr_nx  = ch_addr_a[rr_gnt];
          last_ctrl_nx = 1'b0;
          rom_cs_nx    = 1'b1;
          cnt_nx       = '0;
          state_nx     = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt == 8'(SETTLE - 1)) begin
          cnt_nx   = '0;
          state_nx = ST_WAIT;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      ST_WAIT: begin
        // rom_ok is checked first so a simultaneous expiry still returns real data.
        if (rom_ok) begin
          capture   = 1'b1;
          cap       = rom_data;
          rom_cs_nx = 1'b0;
          state_nx  = ST_DONE;
        end else if (tout_hit) begin
          capture    = 1'b1;
          rom_cs_nx  = 1'b0;
          timeout_nx = 1'b1;
          state_nx   = ST_DONE;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      ST_DONE: begin
        if (id != REQ_CTRL) rr_ptr_nx = id[1:0] + 2'd1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase

    if (capture) begin
      if (id == REQ_CTRL) ctrl_data_nx = cap;
      else                ch_data_nx   = cap;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      id        <= '0;
      rr_ptr    <= '0;
      last_ctrl <= 1'b0;
      rom_addr  <= '0;
      rom_cs    <= 1'b0;
      timeout   <= 1'b0;
      ctrl_data <= '0;
      ch_data   <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      id        <= id_nx;
      rr_ptr    <= rr_ptr_nx;
      last_ctrl <= last_ctrl_nx;
      rom_addr  <= rom_addr_nx;
      rom_cs    <= rom_cs_nx;
      timeout   <= timeout_nx;
      ctrl_data <= ctrl_data_nx;
      ch_data   <= ch_data_nx;
    end
  end

  // Strobes are qualified by the live request so a withdrawn requester gets nothing.
  assign ctrl_ok = (state == ST_DONE) && (id == REQ_CTRL) && ctrl_req;
  assign ch_ok   = ((state == ST_DONE) && (id != REQ_CTRL) && ch_req[id[1:0]])
                   ? (4'b0001 << id[1:0]) : 4'b0000;
endmodule

// File: tb/tb_jt6295_rom_arb.sv
// Randomized scoreboard bench for jt6295_rom_arb: a transaction-level arbitration
// model predicts each strobe (who, data, cycle); a monitor checks what the DUT presents.
module tb_jt6295_rom_arb;
  import jt6295_pkg::*;

  localparam int TOUT_P = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ctrl_req = 1'b0;
  logic [9:0]  ctrl_addr = '0;
  logic [7:0]  ctrl_data;
  logic        ctrl_ok;
  logic [3:0]  ch_req = '0;
  logic [71:0] ch_addr = '0;
  logic [7:0]  ch_data;
  logic [3:0]  ch_ok;
  logic [17:0] rom_addr;
  logic        rom_cs;
  logic [7:0]  rom_data = '0;
  logic        rom_ok = 1'b0;
  logic        timeout;

  jt6295_rom_arb #(.SETTLE(1), .TOUT(TOUT_P)) dut (
    .clk       (clk),
    .rst       (rst),
    .ctrl_req  (ctrl_req),
    .ctrl_addr (ctrl_addr),
    .ctrl_data (ctrl_data),
    .ctrl_ok   (ctrl_ok),
    .ch_req    (ch_req),
    .ch_addr   (ch_addr),
    .ch_data   (ch_data),
    .ch_ok     (ch_ok),
    .rom_addr  (rom_addr),
    .rom_cs    (rom_cs),
    .rom_data  (rom_data),
    .rom_ok    (rom_ok),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0] who;   // {ctrl, ch3..ch0}
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Model of the arbitration policy state at transaction level.
  int rr_m        = 0;
  bit last_ctrl_m = 0;
  bit tout_m      = 0;

  // The ROM's latency and contents are pure functions of the address.
  function automatic int delay_of(input logic [17:0] a);
    logic [17:0] h;
    h = (a ^ (a >> 7)) % 18'd11;
    return int'(h);
  endfunction

  function automatic logic [7:0] data_of(input logic [17:0] a);
    logic [17:0] h;
    h = (a * 18'd29) ^ (a >> 9);
    return h[7:0];
  endfunction

  function automatic logic [17:0] find_addr(input int dmin, input int dmax);
    logic [17:0] a;
    a = 18'($urandom);
    while (delay_of(a) < dmin || delay_of(a) > dmax) a = 18'($urandom);
    return a;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // ROM responder: random rom_ok noise while idle and during settle, real answer after delay_of.
  int k = 0;
  always @(posedge clk) begin
    #1;
    if (rom_cs !== 1'b1) begin
      k        = 0;
      rom_ok   = 1'($urandom_range(0, 1));
      rom_data = 8'($urandom);
    end else begin
      k++;
      if (k == 1) begin
        rom_ok   = 1'($urandom_range(0, 1));
        rom_data = 8'($urandom);
      end else begin
        rom_ok   = (k >= 2 + delay_of(rom_addr));
        rom_data = rom_ok ? data_of(rom_addr) : 8'($urandom);
      end
    end
  end

  // Monitor: every strobe pops one expectation.
  always @(negedge clk) begin
    logic [4:0] who;
    logic [7:0] d;
    exp_t       e;
    if (ctrl_ok !== 1'b0 || ch_ok !== 4'b0000) begin
      who = {ctrl_ok, ch_ok};
      d   = ctrl_ok ? ctrl_data : ch_data;
      n_vec++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_strobe: got who=%b data=%h cycle=%0d, required no strobe", who, d, cyc);
      end else begin
        e = sb.pop_front();
        if (who !== e.who || d !== e.data || cyc != e.at) begin
          n_miss++;
          $display("FAIL strobe: got who=%b data=%h cycle=%0d, required who=%b data=%h cycle=%0d",
                   who, d, cyc, e.who, e.data, e.at);
        end
      end
    end
  end

  // Holds the given requests for len cycles starting now, predicting every completion,
  // then withdraws them and lets any in-flight access drain.
  task automatic run_episode(input bit c_req, input logic [9:0] c_addr, input logic [3:0] reqs,
                             input logic [71:0] addrs, input int len);
    int          s, t, w, d;
    logic [17:0] a;
    exp_t        e;
    ctrl_req  = c_req;
    ctrl_addr = c_addr;
    ch_req    = reqs;
    ch_addr   = addrs;
    s = cyc;
    t = s;
    while (t < s + len) begin
      w = -1;
      if (c_req && (!last_ctrl_m || reqs == 4'b0000)) w = 4;
      else
        for (int i = 0; i < 4; i++)
          if (w < 0 && reqs[(rr_m + i) % 4]) w = (rr_m + i) % 4;
      if (w < 0) break;
      last_ctrl_m = (w == 4);
      a = (w == 4) ? {8'd0, c_addr} : addrs[18*w +: 18];
      d = delay_of(a);
      e.at   = t + 3 + ((d > TOUT_P - 1) ? TOUT_P - 1 : d);
      e.data = (d > TOUT_P - 1) ? 8'h00 : data_of(a);
      e.who  = 5'(1 << w);
      if (d > TOUT_P - 1) tout_m = 1'b1;
      if (e.at < s + len) sb.push_back(e);
      if (w != 4) rr_m = (w + 1) % 4;
      t = e.at + 1;
    end
    repeat (len) @(posedge clk);
    #1;
    ctrl_req = 1'b0;
    ch_req   = 4'b0000;
    repeat (14) @(posedge clk);
    #1;
    check("missing_strobes", 64'(sb.size()), 64'd0);
    sb.delete();
    check("timeout_flag", 64'(timeout), 64'(tout_m));
  endtask

  initial begin
    logic [17:0] a;
    logic [71:0] addrs;
    int          s;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_rom_cs",    64'(rom_cs),    64'd0);
    check("rst_rom_addr",  64'(rom_addr),  64'd0);
    check("rst_ctrl_data", 64'(ctrl_data), 64'd0);
    check("rst_ch_data",   64'(ch_data),   64'd0);
    check("rst_oks",       64'({ctrl_ok, ch_ok}), 64'd0);
    check("rst_timeout",   64'(timeout),   64'd0);

    // Single channel, the latency reference case.
    run_episode(1'b0, 10'd0, 4'b0001, {54'd0, 18'h12345}, 6);
    // All channels held: rotating order.
    run_episode(1'b0, 10'd0, 4'b1111,
                {find_addr(0, 3), find_addr(0, 3), find_addr(0, 3), find_addr(0, 3)}, 24);
    // Ctrl against ch2: alternation, ctrl address zero-extended.
    run_episode(1'b1, 10'h3a7, 4'b0100, {18'd0, find_addr(0, 4), 36'd0}, 30);
    // Delay 5, delay 7 (ok on the expiry cycle wins), and a stuck ROM.
    run_episode(1'b0, 10'd0, 4'b0010, {36'd0, find_addr(5, 5), 18'd0}, 10);
    check("no_timeout_yet", 64'(timeout), 64'd0);
    run_episode(1'b0, 10'd0, 4'b1000, {find_addr(7, 7), 54'd0}, 12);
    check("no_timeout_d7", 64'(timeout), 64'd0);
    run_episode(1'b0, 10'd0, 4'b1001, {find_addr(0, 2), 36'd0, find_addr(8, 10)}, 20);

    // Reset in WAIT: nothing completes, outputs clear, held req is granted afresh.
    a = find_addr(8, 10);
    addrs = {54'd0, a};
    ch_req  = 4'b0001;
    ch_addr = addrs;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst2_rom_cs",    64'(rom_cs),    64'd0);
    check("rst2_timeout",   64'(timeout),   64'd0);
    check("rst2_ch_data",   64'(ch_data),   64'd0);
    check("rst2_rom_addr",  64'(rom_addr),  64'd0);
    check("rst2_oks",       64'({ctrl_ok, ch_ok}), 64'd0);
    rr_m = 0;
    last_ctrl_m = 0;
    tout_m = 0;
    run_episode(1'b0, 10'd0, 4'b0001, addrs, 16);

    for (int n = 0; n < 40; n++) begin
      bit         c;
      logic [3:0] r;
      c = 1'($urandom_range(0, 1));
      r = 4'($urandom);
      if (!c && r == 4'b0000) r = 4'b0001;
      s = $urandom_range(3, 50);
      run_episode(c, 10'($urandom), r, 72'({$urandom, $urandom, $urandom}), s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/jt6295_rom_arb.md
Name: jt6295_rom_arb

Overview:
- Shares the single ADPCM sample ROM port between two kinds of requester.
  - The phrase-table reader in the control path: 10-bit header addresses in the first 1 KB.
  - The four channel ADPCM fetchers: 18-bit sample addresses.
- Sits between the control/channel logic and the external ROM/SDRAM bridge.
- Serializes accesses, handles the rom_ok handshake with a settle window, and returns data plus a one-cycle ok strobe to the granted requester.

Parameters:
- SETTLE, 1: cycles after an address change during which rom_ok is ignored (range 1-3).
- TOUT, 255: cycles in WAIT before an access is abandoned. 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- ctrl_req  in  1  header read request, level, held until ctrl_ok
- ctrl_addr  in  10  header byte address {phrase, index}
- ctrl_data  out  8  returned header byte
- ctrl_ok  out  1  one-cycle strobe, ctrl_data valid
- ch_req  in  4  per-channel fetch request, level
- ch_addr  in  72  four 18-bit addresses, channel n at [18n+17:18n]
- ch_data  out  8  returned sample byte, shared by all channels
- ch_ok  out  4  one-hot one-cycle strobe to the served channel
- rom_addr  out  18  external ROM address
- rom_cs  out  1  external access active
- rom_data  in  8  external data
- rom_ok  in  1  external data valid for the current rom_addr
- timeout  out  1  sticky flag, set when any access times out

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, timeout 0.
- IDLE:
  - If ctrl_req is high and the previous grant was not ctrl (or no channel is requesting), grant ctrl.
  - Otherwise grant the first requesting channel, searching from rr_ptr upward mod 4.
  - Ctrl has priority but can never win twice in a row while any ch_req is high, so channels cannot starve.
  - On grant: latch requester id and address, drive rom_addr, raise rom_cs, go to SETTLE.
  - For a ctrl grant, rom_addr = {8'd0, ctrl_addr}.
- SETTLE: count SETTLE cycles, then go to WAIT. rom_ok is ignored throughout.
- WAIT:
  - On rom_ok=1, capture rom_data into the requester's data register, drop rom_cs, go to DONE.
  - If TOUT>0 and TOUT cycles elapse without rom_ok, drop rom_cs, set timeout, go to DONE with data forced to 8'h00.
- DONE:
  - Pulse ctrl_ok or ch_ok[id] for exactly one cycle, but only if that requester's req is still high. If req has been withdrawn, no strobe is issued.
  - On a channel grant, rr_ptr = id+1 mod 4.
  - Return to IDLE.
- Latency with rom_ok tied high and SETTLE=1:
  - req seen at IDLE in cycle 0.
  - rom_addr and rom_cs valid in cycle 1.
  - Data sampled at the end of cycle 2.
  - ok high in cycle 3.
  - Back-to-back throughput is one access per 4 cycles.
- Data outputs hold their last value until the next capture for the same destination (ctrl_data or ch_data).
- Requests arriving during an access wait; no queueing beyond the level req.
- A requester must not change its address while req is high. A changed address is not re-sampled.
- Simultaneous rom_ok and timeout expiry: rom_ok wins, and timeout is not set.
- rst mid-access: immediately IDLE, rom_cs=0, no ok strobe. An in-flight external access is abandoned.
- rom_addr holds its last value when idle, so the bridge cache is not disturbed.

Decomposition:
- Shared package jt6295_pkg, containing:
  - state encoding ST_IDLE/ST_SETTLE/ST_WAIT/ST_DONE
  - CH_N=4
  - ROM_AW=18
  - REQ_CTRL id constant (4, beyond the channel ids 0-3)
- One natural sub-module: jt6295_rr4, a combinational 4-way round-robin picker. Inputs req[3:0] and ptr[1:0]; outputs gnt id and valid.

Test Plan:
- ch_req=4'b0001, ch_addr[0]=18'h12345, rom_ok=1, rom_data=8'hA5 -> rom_addr=18'h12345 in cycle 1, ch_ok=4'b0001 in cycle 3, ch_data=8'hA5.
- ch_req=4'b1111 held, all data ready -> grant order 0,1,2,3,0, with ch_ok one-hot every 4 cycles.
- ctrl_req and ch_req=4'b0100 both held -> grant order ctrl, ch2, ctrl, ch2; rom_addr for ctrl = 18'h00 concatenated with ctrl_addr.
- rom_ok held low for 5 cycles after settle, then high with rom_data=8'h3C -> ok 5 cycles later than nominal, data 8'h3C. Repeat with rom_ok high only during SETTLE -> the ignored ok does not complete the access.
- TOUT=8, rom_ok stuck low -> rom_cs drops after 8 WAIT cycles, timeout=1, strobe carries data 8'h00, next requester is served.
- rst asserted in WAIT -> rom_cs=0 next cycle, no ok strobe, all outputs at reset values; a req held across reset is granted afresh.
